// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the tamagotchi status link.
//   tx_state_e     : transmit scheduler FSM states
//   grant_e        : identity of the last requester granted the transmitter
//   stats_t        : snapshot of the pet stats carried by a status frame
//   STATUS_HEADER  : default first byte of a status frame
//   FRAME_LEN_BASE : frame length without checksum byte
//   FRAME_LEN_CSUM : frame length with trailing checksum byte
package tamagotchi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ECHO  = 2'd1,
        ST_FRAME = 2'd2
    } tx_state_e;

    typedef enum logic {
        GRANT_ECHO   = 1'b0,
        GRANT_REPORT = 1'b1
    } grant_e;

    typedef struct packed {
        logic [4:0] hunger;
        logic [4:0] happiness;
        logic [4:0] hygiene;
        logic [4:0] energy;
        logic       is_sleeping;
    } stats_t;

    localparam logic [7:0] STATUS_HEADER  = 8'hA5;
    localparam int         FRAME_LEN_BASE = 6;
    localparam int         FRAME_LEN_CSUM = 7;

endpackage

// File: rtl/status_tx_scheduler.sv
// status_tx_scheduler: shares one UART transmitter between the byte echo
// path and the periodic status-frame reporter.
//
// Build option: STATUS_CHECKSUM_EN appends an XOR checksum byte to each frame.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   second            : one-cycle status report request
//   hunger..energy    : live 5-bit stats, is_sleeping live flag
//   rx_valid, rx_data : received byte to echo back
//   tx_valid, tx_data : byte offered to the transmitter, tx_ready accepts it
//   busy              : FSM not idle
//   drop_cnt          : saturating count of echo bytes lost to a full buffer
//
// state  | meaning
// IDLE   | nothing offered; arbitrates pending echo / report requests
// ECHO   | offering the buffered echo byte
// FRAME  | offering status frame byte byte_idx_q from the snapshot
module status_tx_scheduler
    import tamagotchi_pkg::*;
#(
    parameter logic [7:0] HEADER = STATUS_HEADER
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       second,
    input  logic [4:0] hunger,
    input  logic [4:0] happiness,
    input  logic [4:0] hygiene,
    input  logic [4:0] energy,
    input  logic       is_sleeping,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] drop_cnt
);

`ifdef STATUS_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    tx_state_e  state_q, state_d;
    grant_e     last_grant_q, last_grant_d;
    logic       echo_full_q, echo_full_d;
    logic [7:0] echo_data_q, echo_data_d;
    logic       report_pending_q, report_pending_d;
    logic [2:0] byte_idx_q, byte_idx_d;
    stats_t     snap_q, snap_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    logic       echo_req;
    logic       report_req;
    logic       echo_drain;
    logic [7:0] frame_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            last_grant_q     <= GRANT_REPORT;
            echo_full_q      <= 1'b0;
            echo_data_q      <= 8'h00;
            report_pending_q <= 1'b0;
            byte_idx_q       <= 3'd0;
            snap_q           <= '0;
            drop_cnt_q       <= 8'h00;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            echo_full_q      <= echo_full_d;
            echo_data_q      <= echo_data_d;
            report_pending_q <= report_pending_d;
            byte_idx_q       <= byte_idx_d;
            snap_q           <= snap_d;
            drop_cnt_q       <= drop_cnt_d;
        end
    end

    // Frame byte selected from the snapshot; only the index moves while offered,
    // so the byte is stable across a stalled tx_ready.
    always_comb begin
        frame_byte = 8'h00;
        case (byte_idx_q)
            3'd0:    frame_byte = HEADER;
            3'd1:    frame_byte = {3'b000, snap_q.hunger};
            3'd2:    frame_byte = {3'b000, snap_q.happiness};
            3'd3:    frame_byte = {3'b000, snap_q.hygiene};
            3'd4:    frame_byte = {3'b000, snap_q.energy};
            3'd5:    frame_byte = {7'b0000000, snap_q.is_sleeping};
`ifdef STATUS_CHECKSUM_EN
            3'd6:    frame_byte = HEADER ^ {3'b000, snap_q.hunger}
                                ^ {3'b000, snap_q.happiness}
                                ^ {3'b000, snap_q.hygiene}
                                ^ {3'b000, snap_q.energy}
                                ^ {7'b0000000, snap_q.is_sleeping};
`endif
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        echo_full_d      = echo_full_q;
        echo_data_d      = echo_data_q;
        report_pending_d = report_pending_q | second;
        byte_idx_d       = byte_idx_q;
        snap_d           = snap_q;
        drop_cnt_d       = drop_cnt_q;

        // Same-cycle requests count in IDLE so a grant costs no extra cycle.
        echo_req   = echo_full_q | rx_valid;
        report_req = report_pending_q | second;
        echo_drain = (state_q == ST_ECHO) && tx_ready;

        if (echo_drain) begin
            echo_full_d = 1'b0;
        end
        if (rx_valid) begin
            if (!echo_full_q || echo_drain) begin
                echo_full_d = 1'b1;
                echo_data_d = rx_data;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (echo_req && (!report_req || last_grant_q == GRANT_REPORT)) begin
                    state_d      = ST_ECHO;
                    last_grant_d = GRANT_ECHO;
                end else if (report_req) begin
                    state_d          = ST_FRAME;
                    last_grant_d     = GRANT_REPORT;
                    report_pending_d = 1'b0;
                    byte_idx_d       = 3'd0;
                    snap_d           = '{hunger: hunger, happiness: happiness,
                                         hygiene: hygiene, energy: energy,
                                         is_sleeping: is_sleeping};
                end
            end
            ST_ECHO: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (tx_ready) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d    = ST_IDLE;
                        byte_idx_d = 3'd0;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            ST_ECHO: begin
                tx_valid = 1'b1;
                tx_data  = echo_data_q;
            end
            ST_FRAME: begin
                tx_valid = 1'b1;
                tx_data  = frame_byte;
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_status_tx_scheduler.sv
// Directed bench for status_tx_scheduler. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_status_tx_scheduler;

`ifdef STATUS_CHECKSUM_EN
    localparam int FLEN = 7;
`else
    localparam int FLEN = 6;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       second;
    logic [4:0] hunger, happiness, hygiene, energy;
    logic       is_sleeping;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic [7:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_frame [7];

    always #5 clk = ~clk;

    status_tx_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .second      (second),
        .hunger      (hunger),
        .happiness   (happiness),
        .hygiene     (hygiene),
        .energy      (energy),
        .is_sleeping (is_sleeping),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_stats(input logic [4:0] h, input logic [4:0] p,
                             input logic [4:0] hy, input logic [4:0] e, input logic s);
        hunger = h; happiness = p; hygiene = hy; energy = e; is_sleeping = s;
    endtask

    task automatic set_exp(input logic [4:0] h, input logic [4:0] p,
                           input logic [4:0] hy, input logic [4:0] e, input logic s);
        exp_frame[0] = 8'hA5;
        exp_frame[1] = {3'b000, h};
        exp_frame[2] = {3'b000, p};
        exp_frame[3] = {3'b000, hy};
        exp_frame[4] = {3'b000, e};
        exp_frame[5] = {7'b0000000, s};
        exp_frame[6] = exp_frame[0] ^ exp_frame[1] ^ exp_frame[2]
                     ^ exp_frame[3] ^ exp_frame[4] ^ exp_frame[5];
    endtask

    task automatic start_report();
        second = 1'b1;
        step();
        second = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        check({tag, "_valid"}, 8'(tx_valid), 8'd0);
        check({tag, "_busy"},  8'(busy),     8'd0);
    endtask

    task automatic echo_chk(input string tag, input logic [7:0] b);
        check({tag, "_valid"}, 8'(tx_valid), 8'd1);
        check({tag, "_data"},  tx_data,      b);
        step();
    endtask

    // Called on the falling edge where byte 0 is offered; returns on the
    // falling edge after the last byte has transferred.
    task automatic run_frame(input string tag, input int stall_at, input int stall_len,
                             input logic [7:0] sec_mask,
                             input int rx_at, input logic [7:0] rx_b,
                             input int rx2_at, input logic [7:0] rx2_b);
        for (int i = 0; i < FLEN; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    tx_ready = 1'b0;
                    check($sformatf("%s_stall%0d_valid", tag, k), 8'(tx_valid), 8'd1);
                    check($sformatf("%s_stall%0d_data", tag, k), tx_data, exp_frame[i]);
                    step();
                end
                tx_ready = 1'b1;
            end
            check($sformatf("%s_b%0d_valid", tag, i), 8'(tx_valid), 8'd1);
            check($sformatf("%s_b%0d_data", tag, i), tx_data, exp_frame[i]);
            second   = sec_mask[i];
            rx_valid = (i == rx_at) || (i == rx2_at);
            rx_data  = (i == rx2_at) ? rx2_b : rx_b;
            step();
            second   = 1'b0;
            rx_valid = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; second = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        set_stats(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) step();
        check("rst_valid", 8'(tx_valid), 8'd0);
        check("rst_data",  tx_data,      8'h00);
        check("rst_busy",  8'(busy),     8'd0);
        check("rst_drop",  drop_cnt,     8'h00);
        reset = 1'b0;
        step();
        idle_chk("idle0");

        // Reference frame, hand-computed bytes (checksum A6).
        set_stats(5'h0A, 5'h14, 5'h1F, 5'h03, 1'b1);
        exp_frame = '{8'hA5, 8'h0A, 8'h14, 8'h1F, 8'h03, 8'h01, 8'hA6};
        start_report();
        run_frame("ref", -1, 0, 8'h00, -1, 8'h00, -1, 8'h00);
        idle_chk("ref_end");

        // Plain echo from idle: offered on the next cycle.
        rx_valid = 1'b1; rx_data = 8'h33;
        step();
        rx_valid = 1'b0;
        echo_chk("e33", 8'h33);
        idle_chk("e33_end");

        // Both at once after an echo grant: report wins, echo follows.
        set_stats(5'h01, 5'h02, 5'h03, 5'h04, 1'b0);
        set_exp(5'h01, 5'h02, 5'h03, 5'h04, 1'b0);
        second = 1'b1; rx_valid = 1'b1; rx_data = 8'h66;
        step();
        second = 1'b0; rx_valid = 1'b0;
        run_frame("rr", -1, 0, 8'h00, -1, 8'h00, -1, 8'h00);
        idle_chk("rr_gap");
        step();
        echo_chk("rr_echo", 8'h66);
        idle_chk("rr_end");

        // Five-cycle stall on byte 2.
        set_stats(5'h11, 5'h12, 5'h13, 5'h14, 1'b1);
        set_exp(5'h11, 5'h12, 5'h13, 5'h14, 1'b1);
        start_report();
        run_frame("stall", 2, 5, 8'h00, -1, 8'h00, -1, 8'h00);
        idle_chk("stall_end");

        // Echo held off until frame end; second rx byte is dropped.
        set_stats(5'h05, 5'h06, 5'h07, 5'h08, 1'b0);
        set_exp(5'h05, 5'h06, 5'h07, 5'h08, 1'b0);
        start_report();
        run_frame("rx", -1, 0, 8'h00, 1, 8'h41, 3, 8'h42);
        idle_chk("rx_gap");
        check("rx_drop", drop_cnt, 8'h01);
        step();
        echo_chk("rx_echo", 8'h41);
        idle_chk("rx_end");

        // Stats change right after frame entry; frame keeps the snapshot.
        set_stats(5'h1A, 5'h1B, 5'h1C, 5'h1D, 1'b1);
        set_exp(5'h1A, 5'h1B, 5'h1C, 5'h1D, 1'b1);
        start_report();
        set_stats(5'h00, 5'h1F, 5'h00, 5'h1F, 1'b0);
        run_frame("snap", -1, 0, 8'h00, -1, 8'h00, -1, 8'h00);
        idle_chk("snap_end");

        // From reset, echo wins; three seconds in one frame coalesce.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_drop", drop_cnt, 8'h00);
        set_stats(5'h02, 5'h04, 5'h06, 5'h08, 1'b1);
        set_exp(5'h02, 5'h04, 5'h06, 5'h08, 1'b1);
        second = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
        step();
        second = 1'b0; rx_valid = 1'b0;
        echo_chk("both_echo", 8'h55);
        idle_chk("both_gap");
        step();
        run_frame("both_f1", -1, 0, 8'b0001_0110, -1, 8'h00, -1, 8'h00);
        idle_chk("both_gap2");
        step();
        run_frame("both_f2", -1, 0, 8'h00, -1, 8'h00, -1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            idle_chk($sformatf("both_quiet%0d", i));
            step();
        end

        // Reset while byte 3 is offered abandons the frame.
        set_stats(5'h09, 5'h0B, 5'h0C, 5'h0D, 1'b0);
        set_exp(5'h09, 5'h0B, 5'h0C, 5'h0D, 1'b0);
        start_report();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_b%0d_data", i), tx_data, exp_frame[i]);
            step();
        end
        check("abort_b3_data", tx_data, exp_frame[3]);
        reset = 1'b1;
        step();
        idle_chk("abort_rst");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            idle_chk($sformatf("abort_quiet%0d", i));
        end
        start_report();
        check("abort_new_valid", 8'(tx_valid), 8'd1);
        check("abort_new_data",  tx_data,      8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
